// File: rtl/oam_dma_controller_pkg.sv
// Shared constants for the sprite (OAM) DMA controller: FSM encodings, default
// register/port addresses and bus rw encodings.
package oam_dma_controller_pkg;

  localparam logic [2:0] OAM_DMA_IDLE  = 3'd0;
  localparam logic [2:0] OAM_DMA_HALT  = 3'd1;
  localparam logic [2:0] OAM_DMA_ALIGN = 3'd2;
  localparam logic [2:0] OAM_DMA_READ  = 3'd3;
  localparam logic [2:0] OAM_DMA_WRITE = 3'd4;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma_controller_bus_owner_mux.sv
// bus_owner_mux: combinational selector handing the system bus to either the
// CPU core or the DMA sequencer, keyed on dma_active.
module oam_dma_controller_bus_owner_mux (
  input  logic        dma_active,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_rw,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rw
);

  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_rw    = cpu_rw;
    if (dma_active) begin
      bus_addr  = dma_addr;
      bus_wdata = dma_wdata;
      bus_rw    = dma_rw;
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// 2A03 sprite DMA: halts the CPU, copies one page to the PPU OAM data port and
// arbitrates the bus. Define OAM_DMA_ALIGN_EN to insert the odd-parity ALIGN cycle.
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  output logic        cpu_halt,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rw,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

`ifdef OAM_DMA_ALIGN_EN
  localparam logic AlignEn = 1'b1;
`else
  localparam logic AlignEn = 1'b0;
`endif

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  idx_q, page_q, latch_q;
  logic        parity_q;
  logic        trigger;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_rw;

  assign trigger = (state_q == OAM_DMA_IDLE) && (cpu_rw == RW_WRITE) &&
                   (cpu_addr == DMA_REG_ADDR);

  assign dma_active = (state_q != OAM_DMA_IDLE);
  assign cpu_halt   = dma_active;

  always_comb begin
    state_d   = state_q;
    dma_addr  = cpu_addr;
    dma_wdata = latch_q;
    dma_rw    = RW_READ;
    case (state_q)
      OAM_DMA_IDLE: begin
        if (trigger) state_d = OAM_DMA_HALT;
      end
      OAM_DMA_HALT: begin
        // Dummy read on the CPU's address while the core settles.
        state_d = (AlignEn && parity_q) ? OAM_DMA_ALIGN : OAM_DMA_READ;
      end
      OAM_DMA_ALIGN: begin
        state_d = OAM_DMA_READ;
      end
      OAM_DMA_READ: begin
        dma_addr = {page_q, idx_q};
        state_d  = OAM_DMA_WRITE;
      end
      OAM_DMA_WRITE: begin
        dma_addr = OAM_DATA_ADDR;
        dma_rw   = RW_WRITE;
        state_d  = (idx_q == LastIdx) ? OAM_DMA_IDLE : OAM_DMA_READ;
      end
      default: begin
        state_d = OAM_DMA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= OAM_DMA_IDLE;
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      latch_q  <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      state_q  <= state_d;
      if (trigger) page_q <= cpu_wdata;
      if (state_q == OAM_DMA_READ) latch_q <= bus_rdata;
      if (state_q == OAM_DMA_WRITE) begin
        idx_q <= (idx_q == LastIdx) ? 8'h00 : idx_q + 8'h01;
      end
    end
  end

  oam_dma_controller_bus_owner_mux u_bus_owner_mux (
    .dma_active (dma_active),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rw     (cpu_rw),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rw     (dma_rw),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rw     (bus_rw)
  );

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller; expected cycle counts follow OAM_DMA_ALIGN_EN.
module tb_oam_dma_controller;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h8000;
  logic [7:0]  cpu_wdata = 8'hC3;
  logic        cpu_rw = 1'b1;
  logic        cpu_halt;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic [7:0]  bus_rdata;
  logic        dma_active;
  logic        par_model = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  // Memory image: page p, offset i holds i ^ p ^ 8'h58 (page 2 gives i ^ 8'h5A).
  assign bus_rdata = bus_addr[7:0] ^ bus_addr[15:8] ^ 8'h58;

  always @(posedge clock) par_model <= reset ? 1'b0 : ~par_model;

  oam_dma_controller dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rw     (cpu_rw),
    .cpu_halt   (cpu_halt),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rw     (bus_rw),
    .bus_rdata  (bus_rdata),
    .dma_active (dma_active)
  );

  task automatic test_reset();
    reset = 1'b1;
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_wdata = 8'hC3;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (cpu_halt !== 1'b0 || dma_active !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: halt=%b active=%b, want 0 0", cpu_halt, dma_active);
    end
    vectors++;
    if (bus_addr !== 16'h8000 || bus_rw !== 1'b1 || bus_wdata !== 8'hC3) begin
      miscompares++;
      $display("FAIL reset_passthru: addr=%h rw=%b wdata=%h, want 8000 1 c3",
               bus_addr, bus_rw, bus_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_no_trigger();
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_wdata = 8'h02;
      end else if (c < 8) begin
        cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_wdata = 8'h02;
      end else begin
        cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_wdata = 8'hC3;
      end
      @(negedge clock);
      vectors++;
      if (cpu_halt !== 1'b0 || dma_active !== 1'b0 || bus_addr !== cpu_addr ||
          bus_rw !== cpu_rw || bus_wdata !== cpu_wdata) begin
        miscompares++;
        $display("FAIL no_trigger[%0d]: halt=%b addr=%h rw=%b wdata=%h, want 0 %h %b %h",
                 c, cpu_halt, bus_addr, bus_rw, bus_wdata, cpu_addr, cpu_rw, cpu_wdata);
      end
    end
  endtask

  // mode 0: trigger now; 1: HALT on even parity; 2: HALT on odd parity.
  task automatic do_transfer(input logic [7:0] page, input int mode, input string tag);
    int halted = 0, writes = 0, reads = 0, dummies = 0;
    int bad_data = 0, bad_waddr = 0, bad_raddr = 0, bad_flags = 0;
    bit done = 1'b0;
    bit extra;
    if ((mode == 1 && par_model == 1'b0) || (mode == 2 && par_model == 1'b1)) @(negedge clock);
    extra = AlignEn && (par_model == 1'b0);
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_wdata = page;
    @(posedge clock);
    #1;
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_wdata = 8'hC3;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        vectors++;
        if (cpu_halt !== 1'b1) begin
          miscompares++;
          $display("FAIL %s halt_rise: halt=%b, want 1", tag, cpu_halt);
        end
      end
      if (cpu_halt !== dma_active) bad_flags++;
      if (!dma_active) begin
        done = 1'b1;
      end else begin
        halted++;
        if (bus_rw == 1'b0) begin
          if (bus_addr !== 16'h2004) bad_waddr++;
          if (bus_wdata !== (8'(writes) ^ page ^ 8'h58)) bad_data++;
          writes++;
        end else if (bus_addr == 16'h8000) begin
          dummies++;
        end else begin
          if (bus_addr !== {page, 8'(reads)}) bad_raddr++;
          reads++;
        end
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s timeout: dma still active after 600 cycles", tag);
    end
    vectors++;
    if (halted != 513 + int'(extra)) begin
      miscompares++;
      $display("FAIL %s halt_cycles: got %0d, want %0d", tag, halted, 513 + int'(extra));
    end
    vectors++;
    if (writes != 256 || reads != 256) begin
      miscompares++;
      $display("FAIL %s xfer_count: writes=%0d reads=%0d, want 256 256", tag, writes, reads);
    end
    vectors++;
    if (bad_data != 0 || bad_waddr != 0) begin
      miscompares++;
      $display("FAIL %s write_data: bad_data=%0d bad_addr=%0d, want 0 0",
               tag, bad_data, bad_waddr);
    end
    vectors++;
    if (bad_raddr != 0) begin
      miscompares++;
      $display("FAIL %s read_addr: bad=%0d, want 0", tag, bad_raddr);
    end
    vectors++;
    if (dummies != 1 + int'(extra)) begin
      miscompares++;
      $display("FAIL %s dummy_reads: got %0d, want %0d", tag, dummies, 1 + int'(extra));
    end
    vectors++;
    if (bad_flags != 0) begin
      miscompares++;
      $display("FAIL %s halt_vs_active: %0d cycles differ, want 0", tag, bad_flags);
    end
    vectors++;
    if (bus_addr !== 16'h8000 || bus_rw !== 1'b1) begin
      miscompares++;
      $display("FAIL %s end_passthru: addr=%h rw=%b, want 8000 1", tag, bus_addr, bus_rw);
    end
  endtask

  task automatic test_transfer_even();
    do_transfer(8'h02, 1, "even");
  endtask

  task automatic test_transfer_odd();
    do_transfer(8'h02, 2, "odd");
  endtask

  task automatic test_back_to_back();
    do_transfer(8'h02, 0, "b2b_first");
    do_transfer(8'h03, 0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int writes = 0, late_writes = 0;
    bit hit = 1'b0;
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_wdata = 8'h07;
    @(posedge clock);
    #1;
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_wdata = 8'hC3;
    for (int cyc = 0; cyc < 1000 && !hit; cyc++) begin
      @(negedge clock);
      if (dma_active && bus_rw == 1'b0) begin
        if (writes == 100) hit = 1'b1;
        else writes++;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL mid_find: write idx 100 not seen in 1000 cycles");
    end
    vectors++;
    if (bus_addr !== 16'h2004 || bus_wdata !== (8'd100 ^ 8'h07 ^ 8'h58)) begin
      miscompares++;
      $display("FAIL mid_write100: addr=%h data=%h, want 2004 %h",
               bus_addr, bus_wdata, 8'd100 ^ 8'h07 ^ 8'h58);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if (cpu_halt !== 1'b0 || dma_active !== 1'b0 || bus_addr !== cpu_addr || bus_rw !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: halt=%b active=%b addr=%h rw=%b, want 0 0 8000 1",
               cpu_halt, dma_active, bus_addr, bus_rw);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus_rw == 1'b0 || cpu_halt !== 1'b0) late_writes++;
    end
    vectors++;
    if (late_writes != 0) begin
      miscompares++;
      $display("FAIL mid_no_more: %0d cycles with write/halt after reset, want 0", late_writes);
    end
  endtask

  initial begin
    test_reset();
    test_no_trigger();
    test_transfer_even();
    test_transfer_odd();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
